// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: control from EX/ID, the instruction-memory handshake, and the word presented to IF/ID.
interface instr_fetch_unit_if;
  logic        ifu_jump_flag_in;
  logic [31:0] ifu_jump_addr_in;
  logic        ifu_hold_in;
  logic        ifu_mem_req_out;
  logic [31:0] ifu_mem_addr_out;
  logic        ifu_mem_gnt_in;
  logic        ifu_mem_rvalid_in;
  logic [31:0] ifu_mem_rdata_in;
  logic [31:0] ifu_instr_addr_out;
  logic [31:0] ifu_instr_out;
  logic        ifu_instr_valid_out;

  modport master (
    input  ifu_jump_flag_in, ifu_jump_addr_in, ifu_hold_in,
    input  ifu_mem_gnt_in, ifu_mem_rvalid_in, ifu_mem_rdata_in,
    output ifu_mem_req_out, ifu_mem_addr_out,
    output ifu_instr_addr_out, ifu_instr_out, ifu_instr_valid_out
  );

  modport slave (
    output ifu_jump_flag_in, ifu_jump_addr_in, ifu_hold_in,
    output ifu_mem_gnt_in, ifu_mem_rvalid_in, ifu_mem_rdata_in,
    input  ifu_mem_req_out, ifu_mem_addr_out,
    input  ifu_instr_addr_out, ifu_instr_out, ifu_instr_valid_out
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: PC, credit-limited memory requests, return buffer; word visible 1 cycle after rvalid.
// Back-pressure: hold freezes the head word; requests stop once buffered + outstanding words fill the buffer.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          FIFO_DEPTH      = 2
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          CW        = $clog2(FIFO_DEPTH + 1);
  localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C   = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW:0] MAXO_C    = (CW + 1)'(MAX_OUTSTANDING);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   fifo_addr [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   tq_mem [4];
  logic [1:0]    tq_wr;
  logic [1:0]    tq_rd;

  logic jump, rv_eff, credit_ok, req, fire;
  logic fifo_empty, fifo_full, push, pop;
  logic unused_addr_lsb;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign jump       = bus.ifu_jump_flag_in;
  assign rv_eff     = bus.ifu_mem_rvalid_in && (outstanding != '0);
  assign credit_ok  = ({1'b0, outstanding} < MAXO_C) &&
                      (({1'b0, fifo_cnt} + {1'b0, outstanding}) < DEPTH_C);
  assign req        = rst && !jump && credit_ok;
  assign fire       = req && bus.ifu_mem_gnt_in;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  // Returns owed to a superseded PC stream are dropped while discard counts down.
  assign push       = rv_eff && !jump && (discard == '0);
  assign pop        = !fifo_empty && !bus.ifu_hold_in && !jump;

  assign bus.ifu_mem_req_out     = req;
  assign bus.ifu_mem_addr_out    = pc;
  assign bus.ifu_instr_valid_out = !fifo_empty;
  assign bus.ifu_instr_out       = fifo_empty ? INSTR_NOP : fifo_data[rd_ptr];
  assign bus.ifu_instr_addr_out  = fifo_empty ? 32'h0 : fifo_addr[rd_ptr];
  assign unused_addr_lsb         = ^bus.ifu_jump_addr_in[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tq_wr       <= '0;
      tq_rd       <= '0;
    end else begin
      if (fire)   tq_wr <= tq_wr + 2'd1;
      if (rv_eff) tq_rd <= tq_rd + 2'd1;
      outstanding <= outstanding + CW'(fire) - CW'(rv_eff);
      if (jump) begin
        pc       <= {bus.ifu_jump_addr_in[31:2], 2'b00};
        discard  <= outstanding - CW'(rv_eff);
        fifo_cnt <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (fire) pc <= pc + 32'd4;
        if (rv_eff && (discard != '0)) discard <= discard - CW'(1);
        if (push) wr_ptr <= nxt(wr_ptr);
        if (pop)  rd_ptr <= nxt(rd_ptr);
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (fire) tq_mem[tq_wr] <= pc;
    if (push) begin
      fifo_addr[wr_ptr] <= tq_mem[tq_rd];
      fifo_data[wr_ptr] <= bus.ifu_mem_rdata_in;
    end
  end

  assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full && !pop));

endmodule
